// File: rtl/dsmod_ctrl.sv
// dsmod_ctrl: buffers PCM samples in a small FIFO and sequences the delta-sigma modulator
// through prefill, run and a ramp-to-zero stop.
module dsmod_ctrl #(
  parameter int NBIT    = 30,
  parameter int DEPTH   = 4,
  parameter int PREFILL = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_mode_cfg,
  input  logic [1:0]             i_osr_cfg,
  input  logic [NBIT-1:0]        i_s_data,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic                   i_mod_rd,
  output logic [NBIT-1:0]        o_mod_data,
  output logic                   o_ena_mod,
  output logic                   o_mode,
  output logic [1:0]             o_osr,
  output logic                   o_busy,
  output logic                   o_underrun,
  input  logic                   i_clr_underrun,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FILL, RUN, STOP} state_e;
  state_e          state_q, state_d;
  logic [NBIT-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     level_q, level_d;
  logic [NBIT-1:0] data_q;
  logic [1:0]      osr_q;
  logic            stop_rd_q, ena_q, mode_q, busy_q, underrun_q;
  logic            push, pop, flush, empty;
  assign o_s_ready  = level_q != (AW+1)'(DEPTH);
  assign o_level    = level_q;
  assign o_mod_data = data_q;
  assign o_ena_mod  = ena_q;
  assign o_mode     = mode_q;
  assign o_osr      = osr_q;
  assign o_busy     = busy_q;
  assign o_underrun = underrun_q;
  always_comb begin
    empty   = level_q == '0;
    push    = i_s_valid && o_s_ready;
    pop     = state_q == RUN && i_mod_rd && !empty;
    flush   = (state_q == FILL && i_stop) || (state_q == STOP && i_mod_rd && stop_rd_q);
    level_d = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_start && !i_stop ? FILL : IDLE;
      FILL:    state_d = i_stop ? IDLE : level_d >= (AW+1)'(PREFILL) ? RUN : FILL;
      RUN:     state_d = i_stop ? STOP : RUN;
      default: state_d = flush ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      stop_rd_q  <= 1'b0;
      data_q     <= '0;
      ena_q      <= 1'b0;
      mode_q     <= 1'b0;
      osr_q      <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      wptr_q    <= flush ? '0 : wptr_q + AW'(push);
      rptr_q    <= flush ? '0 : rptr_q + AW'(pop);
      ena_q     <= state_d == RUN || state_d == STOP;
      busy_q    <= state_d != IDLE;
      // remembers the zeroing read so the next read in STOP ends the stream
      stop_rd_q <= state_q == STOP && (stop_rd_q || i_mod_rd);
      if (state_q == IDLE && state_d == FILL) begin
        mode_q <= i_mode_cfg;
        osr_q  <= i_osr_cfg;
      end
      if (i_mod_rd && (state_q == RUN || state_q == STOP))
        data_q <= pop ? mem_q[rptr_q] : '0;
      underrun_q <= (state_q == RUN && i_mod_rd && empty) || (underrun_q && !i_clr_underrun);
    end
  always_ff @(posedge i_clk)
    if (push) mem_q[wptr_q] <= i_s_data;
endmodule

// File: tb/tb_dsmod_ctrl.sv
// tb_dsmod_ctrl: scoreboard bench for dsmod_ctrl with a queue-based reference model.
module tb_dsmod_ctrl;
  localparam int NBIT = 30, DEPTH = 4, PREFILL = 2, LW = $clog2(DEPTH) + 1;
  logic            clk = 0, rst = 1, start = 0, stop = 0, mode_cfg = 0, s_valid = 0, mod_rd = 0, clr_und = 0;
  logic [1:0]      osr_cfg = 0;
  logic [NBIT-1:0] s_data = 0;
  logic            s_ready, ena_mod, mode, busy, underrun;
  logic [1:0]      osr;
  logic [NBIT-1:0] mod_data;
  logic [LW-1:0]   level;
  always #5 clk = ~clk;
  dsmod_ctrl #(.NBIT(NBIT), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode_cfg(mode_cfg),
    .i_osr_cfg(osr_cfg), .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_mod_rd(mod_rd), .o_mod_data(mod_data), .o_ena_mod(ena_mod), .o_mode(mode), .o_osr(osr),
    .o_busy(busy), .o_underrun(underrun), .i_clr_underrun(clr_und), .o_level(level)
  );
  typedef struct {
    logic [NBIT-1:0] data;
    logic            ena, mode, busy, und, rdy;
    logic [1:0]      osr;
    logic [LW-1:0]   level;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, errs = 0;
  typedef enum {M_IDLE, M_FILL, M_RUN, M_STOP} mst_e;
  mst_e            m_st = M_IDLE;
  logic [NBIT-1:0] m_fifo[$];
  logic [NBIT-1:0] m_data = 0;
  logic            m_und = 0, m_mode = 0;
  logic [1:0]      m_osr = 0;
  int              m_stop_rds = 0;
  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endfunction
  function automatic void model_step();
    bit   can_push, flush = 0, chk_run = 0, und_set = 0;
    mst_e nxt = m_st;
    if (rst) begin
      m_st = M_IDLE; m_fifo.delete(); m_data = 0; m_und = 0; m_mode = 0; m_osr = 0;
      return;
    end
    can_push = s_valid && m_fifo.size() < DEPTH;
    case (m_st)
      M_IDLE: if (start && !stop) begin m_mode = mode_cfg; m_osr = osr_cfg; nxt = M_FILL; end
      M_FILL: if (stop) begin nxt = M_IDLE; flush = 1; end else chk_run = 1;
      M_RUN: begin
        if (mod_rd) begin
          if (m_fifo.size() > 0) m_data = m_fifo.pop_front();
          else begin m_data = 0; und_set = 1; end
        end
        if (stop) begin nxt = M_STOP; m_stop_rds = 0; end
      end
      M_STOP: if (mod_rd) begin
        m_data = 0;
        if (m_stop_rds == 1) begin flush = 1; nxt = M_IDLE; end
        m_stop_rds = m_stop_rds + 1;
      end
    endcase
    if (und_set) m_und = 1; else if (clr_und) m_und = 0;
    if (flush) m_fifo.delete(); else if (can_push) m_fifo.push_back(s_data);
    if (chk_run && m_fifo.size() >= PREFILL) nxt = M_RUN;
    m_st = nxt;
  endfunction
  function automatic exp_t mk_exp();
    exp_t e;
    e.data  = m_data;
    e.ena   = m_st == M_RUN || m_st == M_STOP;
    e.busy  = m_st != M_IDLE;
    e.mode  = m_mode;
    e.osr   = m_osr;
    e.und   = m_und;
    e.level = LW'(m_fifo.size());
    e.rdy   = m_fifo.size() < DEPTH;
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    model_step();
    exp_q.push_back(mk_exp());
    #1;
  endtask
  task automatic cyc(bit v = 0, logic [NBIT-1:0] d = 0, bit rd = 0, bit st = 0, bit sp = 0, bit clr = 0);
    s_valid = v; s_data = d; mod_rd = rd; start = st; stop = sp; clr_und = clr;
    step();
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mod_data", mod_data, e.data);
      check("ena_mod", ena_mod, e.ena);
      check("busy", busy, e.busy);
      check("mode", mode, e.mode);
      check("osr", osr, e.osr);
      check("underrun", underrun, e.und);
      check("level", level, e.level);
      check("s_ready", s_ready, e.rdy);
    end
  end
  initial begin
    cyc(); cyc();
    rst = 0;
    cyc();
    mode_cfg = 1; osr_cfg = 2;
    cyc(0, 0, 0, 1);
    mode_cfg = 0; osr_cfg = 0;
    cyc(1, 'h1000);
    cyc(1, 'h2000);
    check("ena_at_prefill", ena_mod, 1);
    check("osr_latched", osr, 2);
    check("mode_latched", mode, 1);
    cyc(0, 0, 1);
    check("first_read_data", mod_data, 'h1000);
    check("first_read_level", level, 1);
    cyc(1, 'h3000);
    cyc(1, 'h4000);
    @(negedge clk); #1;
    rst = 1; #1;
    check("arst_level", level, 0);
    check("arst_ready", s_ready, 1);
    check("arst_ena", ena_mod, 0);
    check("arst_busy", busy, 0);
    check("arst_data", mod_data, 0);
    check("arst_osr", osr, 0);
    cyc();
    rst = 0;
    cyc();
    osr_cfg = 1;
    cyc(0, 0, 0, 1);
    cyc(1, 'hA); cyc(1, 'hB); cyc(1, 'hC); cyc(1, 'hD);
    check("full_level", level, 4);
    check("full_ready", s_ready, 0);
    osr_cfg = 3;
    cyc(1, 'hE);
    check("fifth_rejected", level, 4);
    check("osr_held", osr, 1);
    cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(1, 'hF, 1);
    check("push_pop_level", level, 2);
    check("push_pop_data", mod_data, 'hC);
    cyc(0, 0, 1); cyc(0, 0, 1);
    check("order_after_wrap", mod_data, 'hF);
    cyc(0, 0, 1);
    check("underrun_set", underrun, 1);
    check("underrun_ena", ena_mod, 1);
    cyc(0, 0, 1, 0, 0, 1);
    check("underrun_set_wins", underrun, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("underrun_cleared", underrun, 0);
    cyc(1, 'h11); cyc(1, 'h12); cyc(1, 'h13);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1);
    check("stop_zero_data", mod_data, 0);
    check("stop_zero_ena", ena_mod, 1);
    cyc(0, 0, 1);
    check("stop_done_ena", ena_mod, 0);
    check("stop_done_level", level, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 'h21, 0, 1, 1);
    check("fill_abort_busy", busy, 0);
    check("fill_abort_level", level, 0);
    for (int i = 0; i < 3000; i++) begin
      mode_cfg = 1'($urandom); osr_cfg = 2'($urandom);
      cyc(1'($urandom), NBIT'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
    end
    cyc(); cyc();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
